axis_px_packer: RTL and testbench

Output-side width adapter placed directly downstream of the median accelerator's AXIS master port, on the same clock. It takes one 8-bit pixel per 32-bit input beat (byte 0 valid, upper bits ignored), packs four consecutive pixels into one 32-bit output word for the DMA S2MM channel, and flushes a partial word with the correct `tkeep` when input `tlast` arrives. A frame counter reports completed frames to software.

---
 rtl/axis_px_packer.sv | 117 +++++++++++
 tb/tb_axis_px_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_px_packer.sv
// Packs one 8-bit pixel per input beat into 32-bit output words, flushing a
// partial word with matching tkeep on input tlast, and counts completed frames.
module axis_px_packer #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_CNT_W        = 16
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic                            s00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tkeep,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast,
  output logic [FRAME_CNT_W-1:0]          frames_done
);

  // Handshake: a beat moves on either side only in a cycle where valid and
  // ready are both high; valid never waits for ready, and a held output word
  // (data, keep, last) is frozen until it is taken.

  logic [23:0]                   store_q, store_d;
  logic [1:0]                    byte_cnt_q, byte_cnt_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [3:0]                    out_keep_q, out_keep_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic [FRAME_CNT_W-1:0]        frames_q, frames_d;
  logic                          rst_done_q, rst_done_d;

  logic       s_ready;
  logic       in_xfer;
  logic       out_xfer;
  logic       close_word;
  logic [7:0] pixel;
  logic       unused_upper;

  assign pixel        = s00_axis_tdata[7:0];
  assign unused_upper = &{1'b0, s00_axis_tdata[C_AXIS_TDATA_WIDTH-1:8]};

  // Ready only looks at the output stage, never at the input valid/last.
  assign s_ready    = rst_done_q & (~out_valid_q | m00_axis_tready);
  assign in_xfer    = s00_axis_tvalid & s_ready;
  assign out_xfer   = out_valid_q & m00_axis_tready;
  assign close_word = in_xfer & ((byte_cnt_q == 2'd3) | s00_axis_tlast);

  always_comb begin
    store_d     = store_q;
    byte_cnt_d  = byte_cnt_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frames_d    = frames_q;
    rst_done_d  = 1'b1;

    if (out_xfer) begin
      out_valid_d = 1'b0;
      if (out_last_q) frames_d = frames_q + FRAME_CNT_W'(1);
    end

    if (close_word) begin
      // Store is cleared on every close, so bytes above k are already zero;
      // the case still builds each layout explicitly for clarity.
      case (byte_cnt_q)
        2'd0: begin out_data_d = {24'h0, pixel};                 out_keep_d = 4'h1; end
        2'd1: begin out_data_d = {16'h0, pixel, store_q[7:0]};   out_keep_d = 4'h3; end
        2'd2: begin out_data_d = {8'h0, pixel, store_q[15:0]};   out_keep_d = 4'h7; end
        default: begin out_data_d = {pixel, store_q[23:0]};     out_keep_d = 4'hF; end
      endcase
      out_last_d  = s00_axis_tlast;
      out_valid_d = 1'b1;
      store_d     = 24'h0;
      byte_cnt_d  = 2'd0;
    end else if (in_xfer) begin
      case (byte_cnt_q)
        2'd0:    store_d[7:0]   = pixel;
        2'd1:    store_d[15:8]  = pixel;
        default: store_d[23:16] = pixel;
      endcase
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      store_q     <= 24'h0;
      byte_cnt_q  <= 2'd0;
      out_data_q  <= '0;
      out_keep_q  <= 4'h0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frames_q    <= '0;
      rst_done_q  <= 1'b0;
    end else begin
      store_q     <= store_d;
      byte_cnt_q  <= byte_cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frames_q    <= frames_d;
      rst_done_q  <= rst_done_d;
    end
  end

  assign s00_axis_tready = s_ready;
  assign m00_axis_tdata  = out_data_q;
  assign m00_axis_tkeep  = out_keep_q;
  assign m00_axis_tvalid = out_valid_q;
  assign m00_axis_tlast  = out_last_q;
  assign frames_done     = frames_q;

endmodule

// File: tb/tb_axis_px_packer.sv
// Directed bench for axis_px_packer: per-scenario tasks compare captured
// output words against hand-computed {tlast, tkeep, tdata} expectations.
module tb_axis_px_packer;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [15:0] frames_done;

  axis_px_packer #(.C_AXIS_TDATA_WIDTH(32), .FRAME_CNT_W(16)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (s_tready),
    .s00_axis_tlast   (s_tlast),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tkeep   (m_tkeep),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tready  (m_tready),
    .m00_axis_tlast   (m_tlast),
    .frames_done      (frames_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q[$];
  logic [36:0] got_q[$];

  int          bp_pct;
  logic        prev_hold;
  logic [36:0] hold_w;
  int          stab_bad;
  int          rdy_bad;
  int          stall_cnt;
  logic        in_acc;

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    m_tready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    prev_hold = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // One clock: sample outputs at the falling edge, then advance past the
  // next rising edge. Also records transfers and protocol violations.
  task automatic tick();
    logic [36:0] w;
    @(negedge clk);
    w = {m_tlast, m_tkeep, m_tdata};
    if (prev_hold && (!m_tvalid || w !== hold_w)) stab_bad++;
    if (s_tready !== (~m_tvalid | m_tready)) rdy_bad++;
    if (m_tvalid && m_tready) got_q.push_back(w);
    prev_hold = m_tvalid && !m_tready;
    hold_w    = w;
    in_acc    = s_tvalid && s_tready;
    @(posedge clk); #1;
  endtask

  task automatic pick_ready();
    m_tready = (bp_pct == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
  endtask

  task automatic send_px(input logic [7:0] px, input logic last);
    logic [23:0] junk;
    int n;
    junk     = 24'($urandom());
    s_tdata  = {junk, px};
    s_tvalid = 1'b1;
    s_tlast  = last;
    n = 0;
    do begin
      pick_ready();
      tick();
      n++;
    end while (!in_acc && n < 200);
    if (n > 1) stall_cnt += n - 1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] first, input int len);
    for (int i = 0; i < len; i++) send_px(first + 8'(i), i == len - 1);
  endtask

  task automatic drain(input int n);
    int cyc;
    cyc = 0;
    s_tvalid = 1'b0;
    while (got_q.size() < n && cyc < 200) begin
      pick_ready();
      tick();
      cyc++;
    end
    m_tready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tdata  = $urandom();
      s_tvalid = 1'($urandom());
      s_tlast  = 1'($urandom());
      m_tready = 1'($urandom());
      @(negedge clk);
      total++;
      if ({m_tvalid, m_tdata, m_tkeep, m_tlast, frames_done, s_tready} !== 55'h0) begin
        bad++;
        $display("FAIL reset_outputs: got v=%b d=%h k=%h l=%b f=%h r=%b want all 0",
                 m_tvalid, m_tdata, m_tkeep, m_tlast, frames_done, s_tready);
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    rst_n    = 1'b1;
    #2;
    total++;
    if (s_tready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: got %b want 0", s_tready);
    end
    @(posedge clk); #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_edge: got %b want 1", s_tready);
    end
  endtask

  task automatic test_full_words();
    reset_dut();
    bp_pct = 0; stall_cnt = 0; rdy_bad = 0; stab_bad = 0;
    exp_q.push_back({1'b0, 4'hF, 32'h04030201});
    exp_q.push_back({1'b1, 4'hF, 32'h08070605});
    send_frame(8'h01, 8);
    drain(2);
    total++;
    if (got_q.size() != 2) begin bad++; $display("FAIL full_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (frames_done !== 16'd1) begin bad++; $display("FAIL full_frames: got %0d want 1", frames_done); end
    total++;
    if (stall_cnt != 0) begin bad++; $display("FAIL full_stall: got %0d stalls want 0", stall_cnt); end
  endtask

  task automatic test_partial_frames();
    reset_dut();
    bp_pct = 0; stall_cnt = 0;
    exp_q.push_back({1'b0, 4'hF, 32'hA3A2A1A0});
    exp_q.push_back({1'b1, 4'h1, 32'h000000A4});
    exp_q.push_back({1'b0, 4'hF, 32'hA3A2A1A0});
    exp_q.push_back({1'b1, 4'h3, 32'h0000A5A4});
    exp_q.push_back({1'b0, 4'hF, 32'hA3A2A1A0});
    exp_q.push_back({1'b1, 4'h7, 32'h00A6A5A4});
    send_frame(8'hA0, 5);
    send_frame(8'hA0, 6);
    send_frame(8'hA0, 7);
    drain(6);
    total++;
    if (got_q.size() != 6) begin bad++; $display("FAIL partial_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL partial_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (frames_done !== 16'd3) begin bad++; $display("FAIL partial_frames: got %0d want 3", frames_done); end
    total++;
    if (stall_cnt != 0) begin bad++; $display("FAIL back_to_back_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_single_pixel();
    reset_dut();
    bp_pct = 0;
    exp_q.push_back({1'b1, 4'h1, 32'h0000005A});
    send_px(8'h5A, 1'b1);
    drain(1);
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL single_word: got n=%0d %h want %h", got_q.size(), got_q[0], exp_q[0]);
    end
    total++;
    if (frames_done !== 16'd1) begin bad++; $display("FAIL single_frames: got %0d want 1", frames_done); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    bp_pct = 30; stab_bad = 0; rdy_bad = 0;
    exp_q.push_back({1'b0, 4'hF, 32'h24232221});
    exp_q.push_back({1'b0, 4'hF, 32'h28272625});
    exp_q.push_back({1'b1, 4'hF, 32'h2C2B2A29});
    send_frame(8'h21, 12);
    drain(3);
    bp_pct = 0;
    total++;
    if (got_q.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (stab_bad != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stab_bad); end
    total++;
    if (rdy_bad != 0) begin bad++; $display("FAIL bp_ready: got %0d bad cycles want 0", rdy_bad); end
    total++;
    if (frames_done !== 16'd1) begin bad++; $display("FAIL bp_frames: got %0d want 1", frames_done); end
  endtask

  task automatic test_reset_mid_frame();
    reset_dut();
    bp_pct = 0;
    send_px(8'hE0, 1'b0);
    send_px(8'hE1, 1'b0);
    reset_dut();
    exp_q.push_back({1'b1, 4'hF, 32'h14131211});
    send_frame(8'h11, 4);
    drain(1);
    repeat (3) tick();
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL midreset_word: got n=%0d %h want %h", got_q.size(), got_q[0], exp_q[0]);
    end
    total++;
    if (frames_done !== 16'd1) begin bad++; $display("FAIL midreset_frames: got %0d want 1", frames_done); end
  endtask

  task automatic test_wrap();
    reset_dut();
    bp_pct   = 0;
    m_tready = 1'b1;
    s_tdata  = 32'h0000_0033;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    // Input ready stays high, so one single-pixel frame is taken per edge.
    repeat (65535) @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(posedge clk); #1;
    total++;
    if (frames_done !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffff", frames_done); end
    got_q.delete();
    prev_hold = 1'b0;
    send_px(8'h77, 1'b1);
    drain(1);
    total++;
    if (frames_done !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", frames_done); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    bp_pct = 0; prev_hold = 1'b0; hold_w = '0; stab_bad = 0; rdy_bad = 0;
    stall_cnt = 0; in_acc = 1'b0;
    test_reset();
    test_full_words();
    test_partial_frames();
    test_single_pixel();
    test_backpressure();
    test_reset_mid_frame();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
